instruction_fetch: RTL and testbench

//  Fetch stage directly upstream of the control unit. Holds the PC and issues word reads to the
//  I-cache under a stall handshake. Registers the returned instruction in the IF/ID register and

---
 rtl/instruction_fetch.sv | 158 +++++++++++++++
 tb/tb_instruction_fetch.sv | 294 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/instruction_fetch.sv
// ---------------------------------------------------------------------------
// instruction_fetch
//
// Fetch stage that sits directly in front of the control unit. It holds the
// PC, issues one word read at a time to the I-cache, and registers the
// returned instruction in the IF/ID register. It also drives the
// Opcode/Funct7/Funct3 fields to decode.
//
// A 1-entry skid buffer absorbs decode back-pressure. Branch/jump redirects
// are applied even when they arrive while a cache access is still in flight.
//
// Handshakes:
//   I-cache : a request is presented while icache_ren=1. It completes in the
//             first cycle with icache_ren=1 and icache_stall=0 ("accept"),
//             and icache_rdata is valid in that cycle. While stalled, ren and
//             addr are held stable. At most one access is outstanding.
//   Decode  : IF/ID holds a real instruction while ifid_valid=1. The
//             instruction is taken by decode on any edge with id_hold=0. With
//             id_hold=1 and ifid_valid=1 the register is frozen.
//
// Ports:
//   clk, rst_n             clock, asynchronous active-low reset
//   icache_ren/addr        read request, word address = pc[BITS-1:2]
//   icache_stall/rdata     completion flag and instruction word
//   id_hold                decode back-pressure
//   redirect/redirect_pc   one-cycle taken-branch pulse and its target
//   ifid_valid/pc/instr    IF/ID register contents
//   Opcode/Funct7/Funct3   decode fields of ifid_instr
//   dbg_state              FSM state (0 = REQ, 1 = FULL)
// ---------------------------------------------------------------------------
module instruction_fetch #(
  parameter int               BITS      = 32,
  parameter logic [BITS-1:0]  RESET_PC  = '0,
  parameter logic [BITS-1:0]  NOP_INSTR = 'h13
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              icache_ren,
  output logic [BITS-3:0]   icache_addr,
  input  logic              icache_stall,
  input  logic [BITS-1:0]   icache_rdata,
  input  logic              id_hold,
  input  logic              redirect,
  input  logic [BITS-1:0]   redirect_pc,
  output logic              ifid_valid,
  output logic [BITS-1:0]   ifid_pc,
  output logic [BITS-1:0]   ifid_instr,
  output logic [6:0]        Opcode,
  output logic [6:0]        Funct7,
  output logic [2:0]        Funct3,
  output logic [0:0]        dbg_state
);

  localparam logic [0:0] ST_REQ  = 1'b0;
  localparam logic [0:0] ST_FULL = 1'b1;

  logic [0:0]      state;
  logic [BITS-1:0] pc;
  logic [BITS-1:0] skid_pc;
  logic [BITS-1:0] skid_instr;
  logic            pend_valid;
  logic [BITS-1:0] pend_pc;

  logic            in_req;
  logic            accept;
  logic            ifid_open;
  logic [BITS-1:0] redirect_tgt;
  logic            squash;
  logic [BITS-1:0] squash_tgt;
  logic            fetch_to_ifid;
  logic            fetch_to_skid;
  logic            skid_to_ifid;

  assign in_req = (state == ST_REQ);

  // ren is gated by rst_n so that an in-flight request is dropped the moment
  // reset is asserted, not at the next clock edge.
  assign icache_ren  = rst_n & in_req;
  assign icache_addr = pc[BITS-1:2];

  assign accept       = icache_ren & ~icache_stall;
  assign ifid_open    = ~ifid_valid | ~id_hold;
  assign redirect_tgt = redirect_pc & ~BITS'(3);

  // A completing access is thrown away if a redirect arrives in the same
  // cycle or was recorded while the access was stalled. A same-cycle
  // redirect is newer than any saved target, so it takes priority.
  assign squash     = accept & (redirect | pend_valid);
  assign squash_tgt = redirect ? redirect_tgt : pend_pc;

  assign fetch_to_ifid = accept & ~squash & ifid_open;
  assign fetch_to_skid = accept & ~squash & ~ifid_open;
  assign skid_to_ifid  = ~in_req & ~redirect & ~id_hold;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_REQ;
      pc         <= RESET_PC;
      skid_pc    <= '0;
      skid_instr <= '0;
      pend_valid <= 1'b0;
      pend_pc    <= '0;
      ifid_valid <= 1'b0;
      ifid_pc    <= '0;
      ifid_instr <= NOP_INSTR;
    end else begin
      // Program counter
      if (squash) begin
        pc <= squash_tgt;
      end else if (fetch_to_ifid || fetch_to_skid) begin
        pc <= pc + BITS'(4);
      end else if (!in_req && redirect) begin
        pc <= redirect_tgt;
      end

      // Pending redirect target. A redirect during a stall must not disturb
      // the request that the cache is still working on.
      if (squash) begin
        pend_valid <= 1'b0;
      end else if (in_req && icache_stall && redirect) begin
        pend_valid <= 1'b1;
        pend_pc    <= redirect_tgt;
      end

      // Skid buffer and FSM. FULL means the skid buffer is occupied.
      if (fetch_to_skid) begin
        skid_pc    <= pc;
        skid_instr <= icache_rdata;
        state      <= ST_FULL;
      end else if (!in_req && (redirect || !id_hold)) begin
        state <= ST_REQ;
      end

      // IF/ID register. A redirect squashes it regardless of id_hold.
      if (redirect) begin
        ifid_valid <= 1'b0;
        ifid_instr <= NOP_INSTR;
      end else if (fetch_to_ifid) begin
        ifid_valid <= 1'b1;
        ifid_pc    <= pc;
        ifid_instr <= icache_rdata;
      end else if (skid_to_ifid) begin
        ifid_valid <= 1'b1;
        ifid_pc    <= skid_pc;
        ifid_instr <= skid_instr;
      end else if (!id_hold) begin
        ifid_valid <= 1'b0;
        ifid_instr <= NOP_INSTR;
      end
    end
  end

  assign Opcode    = ifid_instr[6:0];
  assign Funct7    = ifid_instr[31:25];
  assign Funct3    = ifid_instr[14:12];
  assign dbg_state = state;

endmodule

// File: tb/tb_instruction_fetch.sv
// ---------------------------------------------------------------------------
// tb_instruction_fetch
//
// Bench for instruction_fetch. It contains:
//   - a directed per-cycle vector table covering streaming, stall, hold/skid,
//     redirects (including a wrap at the top of memory, a redirect during a
//     stall, a redirect in FULL, and an overwritten pending target)
//   - a hand-written reset-during-stall sequence
//   - a randomized run checked against a stream-level model
//
// The model tracks only the expected PC of the next instruction handed to
// decode. It holds the last consumed PC + 4, or the latest redirect target.
// The instruction word must equal the memory image at that PC.
// ---------------------------------------------------------------------------
module tb_instruction_fetch;

  localparam logic [31:0] NOP = 32'h0000_0013;

  // Clock / reset
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  always #5 clk = ~clk;

  // DUT signals
  logic        icache_ren;
  logic [29:0] icache_addr;
  logic        icache_stall = 1'b0;
  logic [31:0] icache_rdata;
  logic        id_hold = 1'b0;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic [6:0]  Opcode;
  logic [6:0]  Funct7;
  logic [2:0]  Funct3;
  logic [0:0]  dbg_state;

  instruction_fetch #(
    .BITS      (32),
    .RESET_PC  (32'h0),
    .NOP_INSTR (32'h0000_0013)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .icache_ren   (icache_ren),
    .icache_addr  (icache_addr),
    .icache_stall (icache_stall),
    .icache_rdata (icache_rdata),
    .id_hold      (id_hold),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .ifid_valid   (ifid_valid),
    .ifid_pc      (ifid_pc),
    .ifid_instr   (ifid_instr),
    .Opcode       (Opcode),
    .Funct7       (Funct7),
    .Funct3       (Funct3),
    .dbg_state    (dbg_state)
  );

  // Memory image: word 0 is addi x1,x0,5, and every other word is a hash of
  // its address.
  function automatic logic [31:0] mem_word(input logic [29:0] wa);
    if (wa == 30'd0) return 32'h0050_0093;
    return (32'(wa) * 32'h9E37_79B1) ^ 32'h5A5A_5A5A;
  endfunction

  assign icache_rdata = mem_word(icache_addr);

  // Scoreboard state
  int          n_checks = 0;
  int          n_fail   = 0;
  int          n_cons   = 0;
  logic [31:0] exp_pc   = '0;
  logic [31:0] exp_q[$];
  bit          use_q    = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock cycle. Inputs must already be set. The stream model and the
  // stall-stability rule are evaluated around the edge.
  task automatic tick();
    logic        cons;
    logic [31:0] c_pc;
    logic [31:0] c_ins;
    logic        was_redir;
    logic [31:0] tgt;
    logic        was_stalled;
    logic [29:0] p_addr;
    cons        = ifid_valid & ~id_hold & ~redirect;
    c_pc        = ifid_pc;
    c_ins       = ifid_instr;
    was_redir   = redirect;
    tgt         = redirect_pc & 32'hFFFF_FFFC;
    was_stalled = icache_ren & icache_stall;
    p_addr      = icache_addr;
    @(posedge clk);
    #1;
    if (cons) begin
      n_cons++;
      check("stream_pc", c_pc, exp_pc);
      check("stream_instr", c_ins, mem_word(c_pc[31:2]));
      if (use_q) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_extra: consumed pc %h, none expected", c_pc);
        end else begin
          logic [31:0] e;
          e = exp_q.pop_front();
          if (c_pc !== e) begin
            n_fail++;
            $display("FAIL sb_pc: got %h expected %h", c_pc, e);
          end
        end
      end
      exp_pc = c_pc + 32'd4;
    end
    if (was_redir) begin
      exp_pc = tgt;
      check("redir_valid", ifid_valid, 0);
      check("redir_instr", ifid_instr, NOP);
    end
    if (was_stalled) begin
      check("stall_ren", icache_ren, 1);
      check("stall_addr", icache_addr, p_addr);
    end
  endtask

  task automatic do_reset();
    rst_n        = 1'b0;
    icache_stall = 1'b0;
    id_hold      = 1'b0;
    redirect     = 1'b0;
    redirect_pc  = '0;
    exp_pc       = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ren", icache_ren, 0);
    check("rst_valid", ifid_valid, 0);
    check("rst_instr", ifid_instr, NOP);
    check("rst_ifid_pc", ifid_pc, 0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("first_ren", icache_ren, 1);
    check("first_addr", icache_addr, 0);
  endtask

  // Directed vector table
  typedef struct {
    logic        stall;
    logic        hold;
    logic        redir;
    logic [31:0] rpc;
    logic        ren;
    logic [29:0] addr;
    logic        valid;
    logic [31:0] pc;
    logic [31:0] instr;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic s, input logic h, input logic r, input logic [31:0] rpc,
                              input logic ren, input logic [29:0] addr, input logic v,
                              input logic [31:0] pc);
    vec_t x;
    x.stall = s; x.hold = h; x.redir = r; x.rpc = rpc;
    x.ren = ren; x.addr = addr; x.valid = v; x.pc = pc;
    x.instr = v ? mem_word(pc[31:2]) : NOP;
    return x;
  endfunction

  initial begin
    #400000;
    $display("FAIL timeout: simulation did not finish, n_fail=%0d", n_fail);
    $fatal(1, "timeout");
  end

  initial begin
    // Streaming, then a 3-cycle stall
    vecs.push_back(mk(0,0,0,0,            1,30'h1,1,32'h0));
    vecs.push_back(mk(0,0,0,0,            1,30'h2,1,32'h4));
    vecs.push_back(mk(1,0,0,0,            1,30'h2,0,32'h4));
    vecs.push_back(mk(1,0,0,0,            1,30'h2,0,32'h4));
    vecs.push_back(mk(1,0,0,0,            1,30'h2,0,32'h4));
    vecs.push_back(mk(0,0,0,0,            1,30'h3,1,32'h8));
    // Decode hold for two cycles: one word goes into the skid buffer
    vecs.push_back(mk(0,1,0,0,            0,30'h4,1,32'h8));
    vecs.push_back(mk(0,1,0,0,            0,30'h4,1,32'h8));
    vecs.push_back(mk(0,0,0,0,            1,30'h4,1,32'hC));
    vecs.push_back(mk(0,0,0,0,            1,30'h5,1,32'h10));
    // Redirects with no stall, including one that wraps at the top
    vecs.push_back(mk(0,0,1,32'h100,      1,30'h40,0,32'h10));
    vecs.push_back(mk(0,0,0,0,            1,30'h41,1,32'h100));
    vecs.push_back(mk(0,0,1,32'hFFFFFFFE, 1,30'h3FFFFFFF,0,32'h100));
    vecs.push_back(mk(0,0,0,0,            1,30'h0,1,32'hFFFFFFFC));
    vecs.push_back(mk(0,0,0,0,            1,30'h1,1,32'h0));
    // Redirect during a stall
    vecs.push_back(mk(1,0,1,32'h200,      1,30'h1,0,32'h0));
    vecs.push_back(mk(1,0,0,0,            1,30'h1,0,32'h0));
    vecs.push_back(mk(0,0,0,0,            1,30'h80,0,32'h0));
    vecs.push_back(mk(0,0,0,0,            1,30'h81,1,32'h200));
    // Redirect while FULL
    vecs.push_back(mk(0,1,0,0,            0,30'h82,1,32'h200));
    vecs.push_back(mk(0,1,1,32'h300,      1,30'hC0,0,32'h200));
    vecs.push_back(mk(0,0,0,0,            1,30'hC1,1,32'h300));
    vecs.push_back(mk(0,1,0,0,            0,30'hC2,1,32'h300));
    vecs.push_back(mk(0,0,0,0,            1,30'hC2,1,32'h304));
    // Pending target overwritten by a later redirect
    vecs.push_back(mk(1,0,1,32'h400,      1,30'hC2,0,32'h304));
    vecs.push_back(mk(1,0,1,32'h500,      1,30'hC2,0,32'h304));
    vecs.push_back(mk(0,0,0,0,            1,30'h140,0,32'h304));
    vecs.push_back(mk(0,0,0,0,            1,30'h141,1,32'h500));

    // ---- Directed table ----
    do_reset();
    exp_q = '{32'h0, 32'h4, 32'h8, 32'hC, 32'hFFFF_FFFC, 32'h300};
    use_q = 1'b1;
    for (int i = 0; i < vecs.size(); i++) begin
      icache_stall = vecs[i].stall;
      id_hold      = vecs[i].hold;
      redirect     = vecs[i].redir;
      redirect_pc  = vecs[i].rpc;
      tick();
      check($sformatf("v%0d_ren", i),    icache_ren, vecs[i].ren);
      check($sformatf("v%0d_addr", i),   icache_addr, vecs[i].addr);
      check($sformatf("v%0d_valid", i),  ifid_valid, vecs[i].valid);
      check($sformatf("v%0d_ifid_pc", i), ifid_pc, vecs[i].pc);
      check($sformatf("v%0d_instr", i),  ifid_instr, vecs[i].instr);
      check($sformatf("v%0d_opcode", i), Opcode, vecs[i].instr[6:0]);
      check($sformatf("v%0d_funct3", i), Funct3, vecs[i].instr[14:12]);
      check($sformatf("v%0d_funct7", i), Funct7, vecs[i].instr[31:25]);
    end
    redirect = 1'b0;
    use_q    = 1'b0;
    check("sb_drain", exp_q.size(), 0);

    // ---- Reset asserted during a stalled access with IF/ID frozen ----
    do_reset();
    repeat (3) tick();
    icache_stall = 1'b1;
    id_hold      = 1'b1;
    repeat (2) tick();
    check("mid_ren_before", icache_ren, 1);
    check("mid_valid_before", ifid_valid, 1);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_ren_async", icache_ren, 0);
    check("mid_valid_async", ifid_valid, 0);
    check("mid_instr_async", ifid_instr, NOP);
    exp_pc = '0;
    @(negedge clk);
    icache_stall = 1'b0;
    id_hold      = 1'b0;
    rst_n        = 1'b1;
    #1;
    check("mid_restart_addr", icache_addr, 0);
    check("mid_restart_ren", icache_ren, 1);
    tick();
    check("mid_restart_valid", ifid_valid, 1);
    check("mid_restart_pc", ifid_pc, 0);
    check("mid_restart_instr", ifid_instr, mem_word(30'h0));

    // ---- Randomized run against the stream model ----
    do_reset();
    n_cons = 0;
    for (int i = 0; i < 3000; i++) begin
      icache_stall = ($urandom_range(0, 9) < 3);
      id_hold      = ($urandom_range(0, 9) < 3);
      redirect     = ($urandom_range(0, 99) < 4);
      redirect_pc  = $urandom();
      tick();
    end
    redirect     = 1'b0;
    icache_stall = 1'b0;
    id_hold      = 1'b0;
    check("rand_liveness", (n_cons >= 100), 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
